// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit stream buffer.
// Optional line-buffered draining is selected with UART_TX_STREAM_LINE_FLUSH_EN.
package uart_pkg;

  localparam int          BYTE_W      = 8;
  localparam logic [7:0]  ASCII_LF    = 8'h0A;
  localparam int          MIN_HOLDOFF = 2;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_HOLD = 1'b1
  } tx_state_e;

endpackage

// File: rtl/uart_fifo_mem.sv
// Byte storage for the stream buffer: synchronous write, asynchronous read.
// Addressing and occupancy are owned by the instantiating block.
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  i_Clk,
  input  logic                  i_Wr_En,
  input  logic [DEPTH_LOG2-1:0] i_Wr_Addr,
  input  logic [BYTE_W-1:0]     i_Wr_Data,
  input  logic [DEPTH_LOG2-1:0] i_Rd_Addr,
  output logic [BYTE_W-1:0]     o_Rd_Data
);

  logic [BYTE_W-1:0] mem_q [2**DEPTH_LOG2];

  // NOTE: storage is deliberately not reset; the pointers decide which entries are valid.
  always_ff @(posedge i_Clk) begin
    if (i_Wr_En) mem_q[i_Wr_Addr] <= i_Wr_Data;
  end

  assign o_Rd_Data = mem_q[i_Rd_Addr];

endmodule

// File: rtl/uart_tx_stream_buffer.sv
// Byte FIFO feeding a UART encoder with an issue-then-holdoff drain handshake.
// Define UART_TX_STREAM_LINE_FLUSH_EN to drain only once a full line (LF) is stored.
module uart_tx_stream_buffer
  import uart_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4,
  parameter int PERIOD_W   = 20
) (
  input  logic                i_Clk,
  input  logic                i_Rst_n,
  input  logic [PERIOD_W-1:0] i_Period,
  input  logic                i_Wr_DV,
  input  logic [7:0]          i_Wr_Byte,
  output logic                o_Full,
  output logic                o_Empty,
  output logic [DEPTH_LOG2:0] o_Count,
  output logic                o_Overflow,
  input  logic                i_Clr_Overflow,
  output logic [7:0]          o_TX_Byte,
  output logic                o_TX_Write_Now,
  input  logic                i_TX_Ready
);

  localparam int PTR_W = DEPTH_LOG2 + 1;

  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic                overflow_q, overflow_d;
  logic                full, empty, push, drop, pop, drain_ok;
  logic [7:0]          rd_data, tx_byte_q;
  logic                write_now_q;
  tx_state_e           state_q;
  logic [PERIOD_W:0]   hold_cnt_q, hold_limit;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                 (wr_ptr_q[PTR_W-2:0] == rd_ptr_q[PTR_W-2:0]);
  assign push  = i_Wr_DV && !full;
  assign drop  = i_Wr_DV && full;
  assign pop   = (state_q == S_IDLE) && drain_ok && i_TX_Ready;

  uart_fifo_mem #(.DEPTH_LOG2(DEPTH_LOG2)) u_mem (
    .i_Clk     (i_Clk),
    .i_Wr_En   (push),
    .i_Wr_Addr (wr_ptr_q[DEPTH_LOG2-1:0]),
    .i_Wr_Data (i_Wr_Byte),
    .i_Rd_Addr (rd_ptr_q[DEPTH_LOG2-1:0]),
    .o_Rd_Data (rd_data)
  );

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    wr_ptr_d   = wr_ptr_q + PTR_W'(push);
    rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
    overflow_d = overflow_q;
    if (drop)                overflow_d = 1'b1;
    else if (i_Clr_Overflow) overflow_d = 1'b0;
  end

  // The encoder raises ready during its own start bit; hold off at least two bit times.
  always_comb begin
    hold_limit = {i_Period, 1'b0};
    if (hold_limit < (PERIOD_W+1)'(MIN_HOLDOFF)) hold_limit = (PERIOD_W+1)'(MIN_HOLDOFF);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q     <= S_IDLE;
      hold_cnt_q  <= '0;
      tx_byte_q   <= 8'h00;
      write_now_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          write_now_q <= 1'b0;
          if (pop) begin
            tx_byte_q   <= rd_data;
            write_now_q <= 1'b1;
            hold_cnt_q  <= '0;
            state_q     <= S_HOLD;
          end
        end
        S_HOLD: begin
          write_now_q <= 1'b0;
          if (hold_cnt_q >= hold_limit) state_q <= S_IDLE;
          else                          hold_cnt_q <= hold_cnt_q + (PERIOD_W+1)'(1);
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef UART_TX_STREAM_LINE_FLUSH_EN
  logic [PTR_W-1:0] lf_count_q, lf_count_d;
  logic             lf_in, lf_out;

  assign lf_in  = push && (i_Wr_Byte == ASCII_LF);
  assign lf_out = pop && (rd_data == ASCII_LF);

  always_comb begin
    lf_count_d = lf_count_q;
    case ({lf_in, lf_out})
      2'b10:   lf_count_d = lf_count_q + PTR_W'(1);
      2'b01:   lf_count_d = lf_count_q - PTR_W'(1);
      default: lf_count_d = lf_count_q;
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) lf_count_q <= '0;
    else          lf_count_q <= lf_count_d;
  end

  // A full buffer must drain even without a line end, or the producer would stall forever.
  assign drain_ok = (lf_count_q != '0) || full;
`else
  assign drain_ok = !empty;
`endif

  assign o_Full         = full;
  assign o_Empty        = empty;
  assign o_Count        = wr_ptr_q - rd_ptr_q;
  assign o_Overflow     = overflow_q;
  assign o_TX_Byte      = tx_byte_q;
  assign o_TX_Write_Now = write_now_q;

endmodule
